// File: rtl/bot_trail_pkg.sv
// bot_trail_pkg: shared constants and types for the breadcrumb-trail recorder.
package bot_trail_pkg;

  localparam int TRAIL_DEPTH_DEF = 16;

  localparam logic [1:0] TRAIL_NONE = 2'b00;
  localparam logic [1:0] TRAIL_OLD  = 2'b10;
  localparam logic [1:0] TRAIL_NEW  = 2'b11;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } trail_pos_t;

endpackage

// File: rtl/bot_trail_match.sv
// bot_trail_match: combinational DEPTH-way position comparator.
// With BOT_TRAIL_FADE_EN defined, the newest matching entry decides whether
// the hit is reported as old (age >= DEPTH/2) or recent.
module bot_trail_match
  import bot_trail_pkg::*;
#(
  parameter int DEPTH = TRAIL_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  trail_pos_t       entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
`ifdef BOT_TRAIL_FADE_EN
  input  logic [PTR_W-1:0] wr_ptr,
`endif
  input  logic [7:0]       row,
  input  logic [7:0]       col,
  input  logic             miss,
  output logic             hit,
  output logic             old
);

`ifdef BOT_TRAIL_FADE_EN
  logic [PTR_W-1:0] idx;

  // Walk entries from oldest to newest so the newest match decides the age.
  always_comb begin
    hit = 1'b0;
    old = 1'b0;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = wr_ptr - PTR_W'(1) - PTR_W'(k);
      if (valid[idx] && entries[idx].x == col && entries[idx].y == row) begin
        hit = 1'b1;
        old = (k >= DEPTH / 2);
      end
    end
    if (miss) begin
      hit = 1'b0;
      old = 1'b0;
    end
  end
`else
  logic [DEPTH-1:0] hits;

  // Any valid matching entry is a hit; there is no age to resolve.
  always_comb begin
    hits = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hits[i] = valid[i] && entries[i].x == col && entries[i].y == row;
    end
    hit = |hits && !miss;
    old = 1'b0;
  end
`endif

endmodule

// File: rtl/bot_trail.sv
// bot_trail: RojoBot breadcrumb-trail recorder with a 2-cycle video overlay query.
// Optional build macro: BOT_TRAIL_FADE_EN (old/recent trail shading).
module bot_trail
  import bot_trail_pkg::*;
#(
  parameter int DEPTH = TRAIL_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     LocX_reg,
  input  logic [7:0]     LocY_reg,
  input  logic           upd_sysregs,
  input  logic           trail_en,
  input  logic           trail_clr,
  input  logic [9:0]     vid_row,
  input  logic [9:0]     vid_col,
  output logic [1:0]     trail_pixel,
  output logic [PTR_W:0] trail_count,
  output logic           trail_full
);

  trail_pos_t       entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W:0]   count;
  trail_pos_t       cur_pos;
  logic             capture;

  logic [7:0]       row_p1;
  logic [7:0]       col_p1;
  logic             miss_p1;
  logic [1:0]       pixel_p2;
  logic             hit;
  logic             old;

  assign cur_pos  = '{x: LocX_reg, y: LocY_reg};
  assign last_ptr = wr_ptr - PTR_W'(1);
  // A clear in the same cycle discards the sample.
  assign capture  = upd_sysregs && trail_en && !trail_clr &&
                    (count == '0 || entries[last_ptr] != cur_pos);

  // Position storage: data only, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (capture) entries[wr_ptr] <= cur_pos;
  end

  // Trail bookkeeping: valid bits, write pointer, saturating count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (trail_clr) begin
      valid  <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (capture) begin
      valid[wr_ptr] <= 1'b1;
      wr_ptr        <= wr_ptr + PTR_W'(1);
      if (count != (PTR_W + 1)'(DEPTH)) count <= count + (PTR_W + 1)'(1);
    end
  end

  // Stage 1: register the query coordinate; off-world coordinates force a miss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_p1  <= '0;
      col_p1  <= '0;
      miss_p1 <= 1'b0;
    end else begin
      row_p1  <= vid_row[7:0];
      col_p1  <= vid_col[7:0];
      miss_p1 <= |vid_row[9:8] || |vid_col[9:8];
    end
  end

  bot_trail_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .entries (entries),
    .valid   (valid),
`ifdef BOT_TRAIL_FADE_EN
    .wr_ptr  (wr_ptr),
`endif
    .row     (row_p1),
    .col     (col_p1),
    .miss    (miss_p1),
    .hit     (hit),
    .old     (old)
  );

  // Stage 2: register the overlay code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_p2 <= TRAIL_NONE;
    end else if (hit) begin
      pixel_p2 <= old ? TRAIL_OLD : TRAIL_NEW;
    end else begin
      pixel_p2 <= TRAIL_NONE;
    end
  end

  assign trail_pixel = pixel_p2;
  assign trail_count = count;
  assign trail_full  = (count == (PTR_W + 1)'(DEPTH));

endmodule

// File: tb/tb_bot_trail.sv
// tb_bot_trail: directed, table-driven bench for bot_trail (DEPTH = 16).
module tb_bot_trail;

  localparam int DEPTH = 16;
  localparam int OP_CAP = 0;
  localparam int OP_QRY = 1;
  localparam int OP_CLR = 2;

`ifdef BOT_TRAIL_FADE_EN
  localparam logic [1:0] EXP_AGED = 2'b10;
`else
  localparam logic [1:0] EXP_AGED = 2'b11;
`endif

  typedef struct {
    int         op;
    logic [9:0] a;
    logic [9:0] b;
    logic [1:0] exp_px;
    int         exp_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] LocX_reg;
  logic [7:0] LocY_reg;
  logic       upd_sysregs;
  logic       trail_en;
  logic       trail_clr;
  logic [9:0] vid_row;
  logic [9:0] vid_col;
  logic [1:0] trail_pixel;
  logic [4:0] trail_count;
  logic       trail_full;

  int checks   = 0;
  int failures = 0;

  bot_trail #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .LocX_reg    (LocX_reg),
    .LocY_reg    (LocY_reg),
    .upd_sysregs (upd_sysregs),
    .trail_en    (trail_en),
    .trail_clr   (trail_clr),
    .vid_row     (vid_row),
    .vid_col     (vid_col),
    .trail_pixel (trail_pixel),
    .trail_count (trail_count),
    .trail_full  (trail_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_cap(input logic [7:0] x, input logic [7:0] y, input logic en);
    @(negedge clk);
    LocX_reg = x; LocY_reg = y; upd_sysregs = 1'b1; trail_en = en;
    @(posedge clk); #1;
    upd_sysregs = 1'b0; trail_en = 1'b1;
  endtask

  task automatic do_clr();
    @(negedge clk);
    trail_clr = 1'b1;
    @(posedge clk); #1;
    trail_clr = 1'b0;
  endtask

  task automatic do_query(input logic [9:0] r, input logic [9:0] c, output logic [1:0] px);
    @(negedge clk);
    vid_row = r; vid_col = c;
    @(posedge clk);
    @(posedge clk); #1;
    px = trail_pixel;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tv[$];
    logic [1:0] px;

    tv.push_back('{OP_CAP, 10'd10,  10'd20, 2'b00, 1});
    tv.push_back('{OP_CAP, 10'd11,  10'd20, 2'b00, 2});
    tv.push_back('{OP_CAP, 10'd11,  10'd21, 2'b00, 3});
    tv.push_back('{OP_QRY, 10'd20,  10'd10, 2'b11, 0});
    tv.push_back('{OP_QRY, 10'd5,   10'd5,  2'b00, 0});
    tv.push_back('{OP_QRY, 10'd21,  10'd11, 2'b11, 0});
    tv.push_back('{OP_QRY, 10'd21,  10'd10, 2'b00, 0});
    tv.push_back('{OP_QRY, 10'h114, 10'd10, 2'b00, 0});
    tv.push_back('{OP_QRY, 10'd20,  10'h20A, 2'b00, 0});
    tv.push_back('{OP_CLR, 10'd0,   10'd0,  2'b00, 0});
    tv.push_back('{OP_QRY, 10'd20,  10'd10, 2'b00, 0});
    tv.push_back('{OP_CAP, 10'd50,  10'd50, 2'b00, 1});
    tv.push_back('{OP_CAP, 10'd50,  10'd50, 2'b00, 1});
    tv.push_back('{OP_CAP, 10'd50,  10'd50, 2'b00, 1});
    tv.push_back('{OP_CAP, 10'd50,  10'd50, 2'b00, 1});
    tv.push_back('{OP_QRY, 10'd50,  10'd50, 2'b11, 0});
    tv.push_back('{OP_CAP, 10'd51,  10'd50, 2'b00, 2});
    tv.push_back('{OP_CAP, 10'd50,  10'd50, 2'b00, 3});

    reset = 1'b0; LocX_reg = '0; LocY_reg = '0; upd_sysregs = 1'b0;
    trail_en = 1'b1; trail_clr = 1'b0; vid_row = '0; vid_col = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pixel", trail_pixel, 0);
    check("reset_count", trail_count, 0);
    check("reset_full",  trail_full,  0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      case (tv[i].op)
        OP_CAP: begin
          do_cap(tv[i].a[7:0], tv[i].b[7:0], 1'b1);
          check($sformatf("vec%0d_count", i), trail_count, tv[i].exp_cnt);
        end
        OP_CLR: begin
          do_clr();
          check($sformatf("vec%0d_count", i), trail_count, tv[i].exp_cnt);
        end
        default: begin
          do_query(tv[i].a, tv[i].b, px);
          check($sformatf("vec%0d_pixel", i), px, tv[i].exp_px);
        end
      endcase
    end

    // capture disabled: no new entry, stored trail still shown
    do_cap(8'd60, 8'd60, 1'b0);
    check("en_off_count", trail_count, 3);
    do_query(10'd60, 10'd60, px);
    check("en_off_pixel", px, 0);
    do_query(10'd50, 10'd51, px);
    check("en_off_shown", px, 3);

    // wrap: 20 distinct positions into 16 slots
    do_clr();
    for (int i = 0; i < 20; i++) begin
      do_cap(8'(i), 8'd0, 1'b1);
      check($sformatf("wrap_count%0d", i), trail_count, (i + 1 > DEPTH) ? DEPTH : i + 1);
      check($sformatf("wrap_full%0d", i), trail_full, (i + 1 >= DEPTH) ? 1 : 0);
    end
    do_query(10'd0, 10'd3, px);
    check("wrap_x3", px, 0);
    do_query(10'd0, 10'd4, px);
    check("wrap_x4", px, EXP_AGED);
    do_query(10'd0, 10'd19, px);
    check("wrap_x19", px, 3);

    // age boundary: 16 entries at x = 0..15
    do_clr();
    check("clr_full", trail_full, 0);
    for (int i = 0; i < 16; i++) do_cap(8'(i), 8'd0, 1'b1);
    do_query(10'd0, 10'd15, px);
    check("fade_x15", px, 3);
    do_query(10'd0, 10'd7, px);
    check("fade_x7", px, EXP_AGED);
    do_query(10'd0, 10'd8, px);
    check("fade_x8", px, 3);

    // clear and capture in the same cycle: clear wins
    @(negedge clk);
    LocX_reg = 8'd99; LocY_reg = 8'd99; upd_sysregs = 1'b1; trail_clr = 1'b1;
    @(posedge clk); #1;
    upd_sysregs = 1'b0; trail_clr = 1'b0;
    check("clrcap_count", trail_count, 0);
    do_query(10'd99, 10'd99, px);
    check("clrcap_pixel", px, 0);
    do_query(10'd0, 10'd15, px);
    check("clrcap_old", px, 0);

    // asynchronous reset mid-stream with 8 entries stored
    for (int i = 0; i < 8; i++) do_cap(8'(30 + i), 8'd1, 1'b1);
    check("pre_rst_count", trail_count, 8);
    do_query(10'd1, 10'd30, px);
    check("pre_rst_pixel", px, EXP_AGED == 2'b10 ? 3 : 3);
    #2;
    reset = 1'b0;
    #1;
    check("rst_pixel", trail_pixel, 0);
    check("rst_count", trail_count, 0);
    check("rst_full",  trail_full,  0);
    @(negedge clk);
    reset = 1'b1;
    do_cap(8'd40, 8'd40, 1'b1);
    check("post_rst_count", trail_count, 1);
    do_query(10'd40, 10'd40, px);
    check("post_rst_new", px, 3);
    do_query(10'd1, 10'd30, px);
    check("post_rst_gone", px, 0);
    do_cap(8'd41, 8'd40, 1'b1);
    check("post_rst_count2", trail_count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bot_trail.md
# bot_trail

Breadcrumb-trail recorder for the RojoBot display path. It samples the bot's world location (LocX/LocY) on every system-register update and stores recent distinct positions in a circular buffer. It answers per-pixel video queries from the VGA subsystem with a 2-bit trail overlay code. It sits downstream of `bot` (location registers and `upd_sysregs`) and upstream of `vga_subsystem`, which merges the trail code with `world_pixel`.

## Interface
Parameters:
- `DEPTH`, 16: number of stored positions; power of two, 4..32.
- `PTR_W`, $clog2(DEPTH): pointer width; derived, do not override.

Ports:
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `LocX_reg`  in  8  bot X position in world coordinates.
- `LocY_reg`  in  8  bot Y position in world coordinates.
- `upd_sysregs`  in  1  one-cycle pulse from `bot`; location is valid in this cycle.
- `trail_en`  in  1  level; when 0, no new positions are captured. The stored trail is still displayed.
- `trail_clr`  in  1  one-cycle synchronous clear of the stored trail.
- `vid_row`  in  10  quartered video row (world coordinates).
- `vid_col`  in  10  quartered video column (world coordinates).
- `trail_pixel`  out  2  overlay code: 00 none, 10 old trail, 11 recent trail.
- `trail_count`  out  PTR_W+1  number of valid entries, 0..DEPTH.
- `trail_full`  out  1  high when `trail_count == DEPTH`.

## Operation
- Storage: DEPTH entries of {X[7:0], Y[7:0]}, a per-entry valid bit, write pointer `wr_ptr`, and a saturating `count`.
- Capture condition: `upd_sysregs & trail_en`, and either the buffer is empty or {LocX_reg, LocY_reg} differs from the last written entry (entry `wr_ptr-1`).
- On capture:
  - write the entry at `wr_ptr` and set its valid bit;
  - increment `wr_ptr` modulo DEPTH (wraps; the oldest entry is overwritten);
  - increment `count`, saturating at DEPTH.
- If the position equals the last entry, nothing changes (duplicates are suppressed).
- `trail_clr` clears all valid bits, `wr_ptr` and `count` to 0.
- If `trail_clr` and a capture occur in the same cycle, the clear wins and the sample is discarded.
- Video query, stage 1: register `vid_row` and `vid_col`.
  - If either has a nonzero bit in [9:8], force a miss.
- Video query, stage 2: compare the registered coordinate against every valid entry (X against col, Y against row) and register the result into `trail_pixel`.
- A hit produces code 11; no hit produces 00. See the macro below for code 10.
- When several entries match, the newest matching entry determines the code.
- Queries are read-only and never stall capture.
- A capture in the same cycle as a compare becomes visible to the compare one cycle later.

## Timing
- Reset values:
  - `trail_pixel` = 00, `trail_count` = 0, `trail_full` = 0;
  - all valid bits = 0, `wr_ptr` = 0;
  - stage registers = 0.
- Reset asserted mid-operation clears everything asynchronously. The first capture is possible on the first `upd_sysregs` after reset deasserts.
- Capture latency: the entry and `trail_count` update on the clock edge that samples `upd_sysregs`; `trail_full` updates in the same cycle.
- Video latency: 2 clocks from `vid_row`/`vid_col` to `trail_pixel`. `vga_subsystem` delays `world_pixel` by 2 to align.
- `trail_clr` takes effect on the next edge; `trail_pixel` shows 00 starting 2 cycles later.

## Configuration
- `BOT_TRAIL_FADE_EN`
  - Defined: compute the age of a matching entry as `(wr_ptr - 1 - idx) mod DEPTH`.
    - Age < DEPTH/2 gives 11 (recent).
    - Age >= DEPTH/2 gives 10 (old).
  - Undefined: every hit gives 11, code 10 is never produced, and no age logic is built.
- Latency is 2 cycles in both builds.

## Structure
- `bot_trail_pkg` holds:
  - `TRAIL_DEPTH_DEF` = 16;
  - pixel codes `TRAIL_NONE` = 2'b00, `TRAIL_OLD` = 2'b10, `TRAIL_NEW` = 2'b11;
  - typedef `trail_pos_t` as a packed {x[7:0], y[7:0]}.
- One sub-module, `bot_trail_match`: the combinational DEPTH-way comparator with newest-hit priority encode, producing hit and (with the macro) old/new. The parent owns all registers.

## Test plan
- Reset release, then 3 `upd_sysregs` pulses at (10,20), (11,20), (11,21) -> `trail_count` = 3; query (row 20, col 10) -> `trail_pixel` = 11 two cycles later; query (5,5) -> 00.
- Pulse `upd_sysregs` 4 times at an unchanged (50,50) -> `trail_count` = 1 (duplicates suppressed).
- Capture 20 distinct positions (x = 0..19, y = 0) with DEPTH = 16 -> `trail_full` = 1, count = 16; query x = 3 -> 00 (overwritten); query x = 4 and x = 19 -> hit.
- `BOT_TRAIL_FADE_EN` defined, 16 entries at x = 0..15 -> x = 15 gives 11, x = 7 gives 10; undefined build -> both give 11.
- `trail_clr` in the same cycle as a capture at (99,99) -> count = 0 and query (99,99) -> 00; query with `vid_row` = 10'h100 -> 00.
- Assert `reset` mid-stream with 8 entries stored -> all outputs 0 immediately; first post-reset capture is stored at index 0.
